// File: rtl/pe8_feeder.sv
// pe8_feeder: gathers operand pairs into 14 PE8 slots, fires the PE8 with the job's
// enable pattern, waits out the PE latency and streams the captured results back.
module pe8_feeder #(
  parameter int N      = 32,
  parameter int Q      = 19,
  parameter int E8     = 10,
  parameter int PE_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [E8-1:0]   i_cfg_en,
  output logic            o_busy,
  input  logic            i_s_valid,
  output logic            o_s_ready,
  input  logic [N-1:0]    i_s_data,
  input  logic [N-1:0]    i_s_weight,
  output logic [14*N-1:0] o_pe_in,
  output logic [14*N-1:0] o_pe_w,
  output logic [E8-1:0]   o_pe_en,
  input  logic [7*N-1:0]  i_pe_res,
  output logic            o_m_valid,
  input  logic            i_m_ready,
  output logic [N-1:0]    o_m_data,
  output logic            o_m_last,
  output logic            o_done
);
  localparam int CW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [CW-1:0] WCNT_LAST = CW'(PE_LAT - 1);

  if (Q >= N || PE_LAT < 1) begin : g_param_check
    $error("pe8_feeder: parameters need Q < N and PE_LAT >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [E8-1:0] r_cfg;
  logic [N-1:0]  r_sd [14];
  logic [N-1:0]  r_sw [14];
  logic [N-1:0]  r_res [7];
  logic [3:0]    r_idx;
  logic [2:0]    r_ridx, w_ridx_nxt;
  logic [CW-1:0] r_wcnt;
  logic          r_s_ready, r_busy, r_m_valid, r_m_last, r_done;
  logic [E8-1:0] r_pe_en;
  logic [N-1:0]  r_m_data, w_m_data_nxt;

  logic       w_full, w_s_hs, w_m_hs, w_wait_done;
  logic [3:0] w_k_last;
  logic [2:0] w_r_last;

  assign w_full      = r_cfg[E8-1];
  assign w_k_last    = w_full ? 4'd7 : 4'd13;
  assign w_r_last    = w_full ? 3'd0 : 3'd6;
  assign w_s_hs      = i_s_valid & r_s_ready;
  assign w_m_hs      = r_m_valid & i_m_ready;
  assign w_wait_done = (r_wcnt == WCNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_ridx_nxt  = r_ridx;
    case (r_state)
      S_IDLE: begin
        w_ridx_nxt = 3'd0;
        if (i_start) w_state_nxt = S_LOAD;
        else         w_state_nxt = S_IDLE;
      end
      S_LOAD: begin
        if (w_s_hs && (r_idx == w_k_last)) w_state_nxt = S_FIRE;
        else                               w_state_nxt = S_LOAD;
      end
      S_FIRE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_wait_done) w_state_nxt = S_DRAIN;
        else             w_state_nxt = S_WAIT;
      end
      S_DRAIN: begin
        if (w_m_hs && (r_ridx == w_r_last)) w_state_nxt = S_IDLE;
        else if (w_m_hs)                    w_ridx_nxt  = r_ridx + 3'd1;
        else                                w_ridx_nxt  = r_ridx;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The first result word bypasses r_res because it is captured on the same edge.
  always_comb begin
    w_m_data_nxt = {N{1'b0}};
    if (w_state_nxt != S_DRAIN)  w_m_data_nxt = {N{1'b0}};
    else if (r_state == S_WAIT)  w_m_data_nxt = i_pe_res[N-1:0];
    else                         w_m_data_nxt = r_res[w_ridx_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg  <= {E8{1'b0}};
      r_idx  <= 4'd0;
      r_ridx <= 3'd0;
      r_wcnt <= {CW{1'b0}};
      for (int k = 0; k < 14; k++) begin
        r_sd[k] <= {N{1'b0}};
        r_sw[k] <= {N{1'b0}};
      end
      for (int k = 0; k < 7; k++) r_res[k] <= {N{1'b0}};
    end else begin
      r_ridx <= w_ridx_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cfg <= i_cfg_en;
            r_idx <= 4'd0;
            for (int k = 0; k < 14; k++) begin
              r_sd[k] <= {N{1'b0}};
              r_sw[k] <= {N{1'b0}};
            end
          end
        end
        S_LOAD: begin
          if (w_s_hs) begin
            r_sd[r_idx] <= i_s_data;
            r_sw[r_idx] <= i_s_weight;
            r_idx       <= r_idx + 4'd1;
          end
        end
        S_FIRE: r_wcnt <= {CW{1'b0}};
        S_WAIT: begin
          r_wcnt <= r_wcnt + {{(CW-1){1'b0}}, 1'b1};
          if (w_wait_done) begin
            for (int k = 0; k < 7; k++) r_res[k] <= i_pe_res[k*N +: N];
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_pe_en   <= {E8{1'b0}};
      r_m_valid <= 1'b0;
      r_m_data  <= {N{1'b0}};
      r_m_last  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_s_ready <= (w_state_nxt == S_LOAD);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_pe_en   <= ((w_state_nxt == S_FIRE) || (w_state_nxt == S_WAIT)) ? r_cfg : {E8{1'b0}};
      r_m_valid <= (w_state_nxt == S_DRAIN);
      r_m_data  <= w_m_data_nxt;
      r_m_last  <= (w_state_nxt == S_DRAIN) && (w_ridx_nxt == w_r_last);
      r_done    <= (r_state == S_DRAIN) && w_m_hs && (r_ridx == w_r_last);
    end
  end

  for (genvar k = 0; k < 14; k++) begin : g_slot
    assign o_pe_in[k*N +: N] = r_sd[k];
    assign o_pe_w[k*N +: N]  = r_sw[k];
  end

  assign o_busy    = r_busy;
  assign o_s_ready = r_s_ready;
  assign o_pe_en   = r_pe_en;
  assign o_m_valid = r_m_valid;
  assign o_m_data  = r_m_data;
  assign o_m_last  = r_m_last;
  assign o_done    = r_done;
endmodule

// File: tb/tb_pe8_feeder.sv
// Self-checking bench for pe8_feeder: directed and randomized jobs compared against
// a job-level model (accepted beats fill slots in order, results come back by slot).
module tb_pe8_feeder;
  localparam int N = 32, Q = 19, E8 = 10, PE_LAT = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_start = 1'b0;
  logic [E8-1:0]   i_cfg_en = '0;
  logic            o_busy;
  logic            i_s_valid = 1'b0;
  logic            o_s_ready;
  logic [N-1:0]    i_s_data = '0, i_s_weight = '0;
  logic [14*N-1:0] o_pe_in, o_pe_w;
  logic [E8-1:0]   o_pe_en;
  logic [7*N-1:0]  i_pe_res;
  logic            o_m_valid;
  logic            i_m_ready = 1'b0;
  logic [N-1:0]    o_m_data;
  logic            o_m_last, o_done;

  logic [N-1:0] bd [16];
  logic [N-1:0] bw [16];
  logic [N-1:0] res_m [7];
  int n_checks = 0, n_fail = 0;

  pe8_feeder #(.N(N), .Q(Q), .E8(E8), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_cfg_en(i_cfg_en), .o_busy(o_busy),
    .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data), .i_s_weight(i_s_weight),
    .o_pe_in(o_pe_in), .o_pe_w(o_pe_w), .o_pe_en(o_pe_en), .i_pe_res(i_pe_res),
    .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data), .o_m_last(o_m_last),
    .o_done(o_done));

  always #5 clk = ~clk;

  always_comb begin
    i_pe_res = '0;
    for (int i = 0; i < 7; i++) i_pe_res[i*N +: N] = res_m[i];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_slots(input int k_n);
    for (int i = 0; i < 14; i++) begin
      chk("pe_in_slot", o_pe_in[i*N +: N], (i < k_n) ? bd[i] : '0);
      chk("pe_w_slot",  o_pe_w[i*N +: N],  (i < k_n) ? bw[i] : '0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_s_ready"}, o_s_ready, 0);
    chk({tag, "_pe_en"}, o_pe_en, 0);
    chk({tag, "_m_valid"}, o_m_valid, 0);
    chk({tag, "_m_data"}, o_m_data, 0);
    chk({tag, "_m_last"}, o_m_last, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pe_in"}, (o_pe_in == '0), 1);
    chk({tag, "_pe_w"}, (o_pe_w == '0), 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      bd[i] = $urandom;
      bw[i] = $urandom;
    end
    for (int i = 0; i < 7; i++) res_m[i] = $urandom;
  endtask

  // Caller raises i_start at a negedge; returns at the negedge where done is seen.
  task automatic run_job(input logic [E8-1:0] cfg, input bit toggle, input int stall,
                         input int stall_word, input bit poke, input int abort_en);
    int k_n = cfg[E8-1] ? 8 : 14;
    int r_n = cfg[E8-1] ? 1 : 7;
    int acc = 0, words = 0, en_cyc = 0, stall_left = stall;
    bit vld, rdy, last_hs = 0, fin = 0, seen_drain = 0, held_ok = 0;
    logic [N-1:0] held = '0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("load_busy", o_busy, 1);
        chk("load_s_ready", o_s_ready, 1);
        chk("done_one_cycle", o_done, 0);
        i_start = 1'b0;
      end
      if (poke && cyc == 2) begin
        i_start  = 1'b1;
        i_cfg_en = ~cfg;
      end else if (poke && cyc == 3) begin
        i_start  = 1'b0;
        i_cfg_en = cfg;
      end
      if (o_pe_en !== '0) begin
        chk("pe_en_value", o_pe_en, cfg);
        if (en_cyc == 0) check_slots(k_n);
        en_cyc++;
        if (abort_en != 0 && en_cyc == abort_en) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("rst_mid_job");
          i_s_valid = 1'b0;
          i_m_ready = 1'b0;
          return;
        end
      end
      if (acc == k_n) chk("s_ready_low_after_k", o_s_ready, 0);
      if (o_done) begin
        chk("done_after_last", last_hs, 1);
        chk("done_busy_low", o_busy, 0);
        chk("words_returned", words, r_n);
        chk("pe_en_cycles", en_cyc, 1 + PE_LAT);
        chk("beats_accepted", acc, k_n);
        fin = 1;
      end
      last_hs   = 0;
      vld       = toggle ? cyc[0] : 1'b1;
      i_s_valid = vld;
      i_s_data  = bd[acc];
      i_s_weight = bw[acc];
      if (o_s_ready && vld) acc++;
      if (o_m_valid) begin
        chk("pe_en_zero_drain", o_pe_en, 0);
        if (!seen_drain) begin
          check_slots(k_n);
          seen_drain = 1;
        end
        if (stall_left > 0 && words == stall_word) begin
          if (held_ok) chk("m_data_hold", o_m_data, held);
          held = o_m_data;
          held_ok = 1;
          stall_left--;
          rdy = 1'b0;
        end else begin
          chk("m_data", o_m_data, res_m[words]);
          chk("m_last", o_m_last, (words == r_n - 1));
          rdy = 1'b1;
          if (o_m_last) last_hs = 1;
          words++;
        end
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      i_m_ready = rdy;
    end
    chk("job_finished", fin, 1);
  endtask

  initial begin
    logic [E8-1:0] cfg;
    for (int i = 0; i < 7; i++) res_m[i] = '0;
    fill_random();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    // Full mode, directed values
    for (int i = 0; i < 16; i++) begin
      bd[i] = 32'h001921FB;
      bw[i] = 32'h00080000;
    end
    res_m[0] = 32'h001921FB;
    i_start = 1'b1; i_cfg_en = 10'b1000000000;
    run_job(10'b1000000000, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("done_cleared", o_done, 0);

    // Partial mode, results 1..7
    fill_random();
    for (int i = 0; i < 7; i++) res_m[i] = 32'(i + 1);
    i_start = 1'b1; i_cfg_en = 10'b0111111111;
    run_job(10'b0111111111, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Backpressure on both streams
    fill_random();
    i_start = 1'b1; i_cfg_en = 10'b0101010101;
    run_job(10'b0101010101, 1, 5, 3, 0, 0);
    @(negedge clk);
    fill_random();
    i_start = 1'b1; i_cfg_en = 10'b1000000011;
    run_job(10'b1000000011, 1, 5, 0, 0, 0);

    // Start during LOAD ignored, then back-to-back start in the done cycle
    fill_random();
    i_start = 1'b1; i_cfg_en = 10'b1000000000;
    run_job(10'b1000000000, 0, 0, 0, 1, 0);
    fill_random();
    cfg = 10'($urandom) & 10'h1FF | 10'h001;
    i_start = 1'b1; i_cfg_en = cfg;
    run_job(cfg, 0, 2, 5, 0, 0);
    @(negedge clk);

    // Reset during WAIT, then a normal job
    fill_random();
    i_start = 1'b1; i_cfg_en = 10'b0011110000;
    run_job(10'b0011110000, 0, 0, 0, 0, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_done_after_abort", o_done, 0);
      chk("idle_after_abort", o_busy, 0);
    end
    fill_random();
    i_start = 1'b1; i_cfg_en = 10'b1111111111;
    run_job(10'b1111111111, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Randomized jobs
    for (int j = 0; j < 4; j++) begin
      fill_random();
      cfg = 10'($urandom) | 10'h001;
      i_start = 1'b1; i_cfg_en = cfg;
      run_job(cfg, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 6), 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
